// File: rtl/switch_allocator.sv
// switch_allocator: separable input-first switch allocator with per-downstream-VC credit counters.
// Define SWITCH_ALLOC_CREDIT_ERR_EN to add a sticky credit_err_o overflow flag.
module switch_allocator #(
    parameter int PORT_NUM = 5,
    parameter int VC_NUM = 2,
    parameter int BUFFER_SIZE = 8,
    localparam int PORT_SIZE = $clog2(PORT_NUM),
    localparam int VC_SIZE = $clog2(VC_NUM),
    localparam int CNT_W = $clog2(BUFFER_SIZE + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic [PORT_NUM*VC_NUM-1:0] request_i,
    input  logic [PORT_NUM*VC_NUM*PORT_SIZE-1:0] out_port_i,
    input  logic [PORT_NUM*VC_NUM*VC_SIZE-1:0] downstream_vc_i,
    input  logic [PORT_NUM*VC_NUM-1:0] credit_i,
    output logic [PORT_NUM*VC_NUM-1:0] read_o,
    output logic [PORT_NUM*PORT_SIZE-1:0] xbar_sel_o,
`ifdef SWITCH_ALLOC_CREDIT_ERR_EN
    output logic credit_err_o,
`endif
    output logic [PORT_NUM-1:0] xbar_valid_o
);
    logic [CNT_W-1:0] cnt [PORT_NUM][VC_NUM];
    logic [VC_SIZE-1:0] p1 [PORT_NUM];
    logic [PORT_SIZE-1:0] p2 [PORT_NUM];
    logic [PORT_NUM*VC_NUM-1:0] elig, csel, dec;
    logic [PORT_NUM-1:0] cand_v;
    always_comb begin
        elig = '0;
        csel = '0;
        cand_v = '0;
        dec = '0;
        read_o = '0;
        xbar_sel_o = '0;
        xbar_valid_o = '0;
        for (int i = 0; i < PORT_NUM; i++)
            for (int v = 0; v < VC_NUM; v++)
                for (int o = 0; o < PORT_NUM; o++)
                    for (int d = 0; d < VC_NUM; d++)
                        if (request_i[i*VC_NUM+v] && out_port_i[(i*VC_NUM+v)*PORT_SIZE +: PORT_SIZE] == PORT_SIZE'(o) && downstream_vc_i[(i*VC_NUM+v)*VC_SIZE +: VC_SIZE] == VC_SIZE'(d) && cnt[o][d] != '0)
                            elig[i*VC_NUM+v] = 1'b1;
        // stage 1: first eligible VC at or after p1, searched in rotation order
        for (int i = 0; i < PORT_NUM; i++)
            for (int k = 0; k < VC_NUM; k++)
                for (int v = 0; v < VC_NUM; v++)
                    if (!cand_v[i] && elig[i*VC_NUM+v] && (int'(p1[i]) + k) % VC_NUM == v) begin
                        cand_v[i] = 1'b1;
                        csel[i*VC_NUM+v] = 1'b1;
                    end
        // stage 2: first candidate input at or after p2 that targets this output
        for (int o = 0; o < PORT_NUM; o++)
            for (int k = 0; k < PORT_NUM; k++)
                for (int i = 0; i < PORT_NUM; i++)
                    for (int v = 0; v < VC_NUM; v++)
                        if (!rst && !xbar_valid_o[o] && csel[i*VC_NUM+v] && out_port_i[(i*VC_NUM+v)*PORT_SIZE +: PORT_SIZE] == PORT_SIZE'(o) && (int'(p2[o]) + k) % PORT_NUM == i) begin
                            xbar_valid_o[o] = 1'b1;
                            xbar_sel_o[o*PORT_SIZE +: PORT_SIZE] = PORT_SIZE'(i);
                            read_o[i*VC_NUM+v] = 1'b1;
                            for (int d = 0; d < VC_NUM; d++)
                                if (downstream_vc_i[(i*VC_NUM+v)*VC_SIZE +: VC_SIZE] == VC_SIZE'(d))
                                    dec[o*VC_NUM+d] = 1'b1;
                        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int o = 0; o < PORT_NUM; o++) begin
                p1[o] <= '0;
                p2[o] <= '0;
                for (int d = 0; d < VC_NUM; d++)
                    cnt[o][d] <= CNT_W'(BUFFER_SIZE);
            end
`ifdef SWITCH_ALLOC_CREDIT_ERR_EN
            credit_err_o <= 1'b0;
`endif
        end else begin
            for (int o = 0; o < PORT_NUM; o++)
                for (int d = 0; d < VC_NUM; d++) begin
                    if (dec[o*VC_NUM+d] && !credit_i[o*VC_NUM+d])
                        cnt[o][d] <= cnt[o][d] - CNT_W'(1);
                    else if (!dec[o*VC_NUM+d] && credit_i[o*VC_NUM+d] && cnt[o][d] != CNT_W'(BUFFER_SIZE))
                        cnt[o][d] <= cnt[o][d] + CNT_W'(1);
`ifdef SWITCH_ALLOC_CREDIT_ERR_EN
                    if (!dec[o*VC_NUM+d] && credit_i[o*VC_NUM+d] && cnt[o][d] == CNT_W'(BUFFER_SIZE))
                        credit_err_o <= 1'b1;
`endif
                end
            for (int i = 0; i < PORT_NUM; i++)
                for (int v = 0; v < VC_NUM; v++)
                    if (read_o[i*VC_NUM+v])
                        p1[i] <= VC_SIZE'((v + 1) % VC_NUM);
            for (int o = 0; o < PORT_NUM; o++)
                for (int i = 0; i < PORT_NUM; i++)
                    if (xbar_valid_o[o] && xbar_sel_o[o*PORT_SIZE +: PORT_SIZE] == PORT_SIZE'(i))
                        p2[o] <= PORT_SIZE'((i + 1) % PORT_NUM);
        end
    end
endmodule

// File: tb/tb_switch_allocator.sv
// tb_switch_allocator: directed and randomized checks of switch_allocator against a distance-based allocation model.
module tb_switch_allocator;
    localparam int PN = 5, VN = 2, BS = 8;
    logic clk = 1'b0, rst;
    logic [PN*VN-1:0] req, cr, read_o, dvc;
    logic [PN*VN*3-1:0] op;
    logic [PN*3-1:0] sel;
    logic [PN-1:0] valid;
`ifdef SWITCH_ALLOC_CREDIT_ERR_EN
    logic err;
`endif
    int mcnt [PN][VN];
    int mp1 [PN];
    int mp2 [PN];
    int gin [PN];
    int gvc [PN];
    bit merr;
    logic [PN*VN-1:0] e_read;
    logic [PN*3-1:0] e_sel;
    logic [PN-1:0] e_valid;
    int n_checks = 0, n_fail = 0;
    int rot [3] = '{0, 1, 3};

    always #5 clk = ~clk;

    switch_allocator dut (
        .clk(clk), .rst(rst), .request_i(req), .out_port_i(op), .downstream_vc_i(dvc), .credit_i(cr),
        .read_o(read_o), .xbar_sel_o(sel),
`ifdef SWITCH_ALLOC_CREDIT_ERR_EN
        .credit_err_o(err),
`endif
        .xbar_valid_o(valid)
    );

    function automatic int op_of(int i, int v);
        return int'(op[(i*VN+v)*3 +: 3]);
    endfunction

    function automatic int dv_of(int i, int v);
        return int'(dvc[i*VN+v]);
    endfunction

    // Winners are the requesters with the smallest rotational distance from each pointer.
    function automatic void model_eval();
        int cand [PN];
        int best, win;
        e_read = '0;
        e_sel = '0;
        e_valid = '0;
        for (int i = 0; i < PN; i++) begin
            cand[i] = -1;
            best = VN;
            for (int v = 0; v < VN; v++)
                if (req[i*VN+v] && mcnt[op_of(i, v)][dv_of(i, v)] > 0 && (v - mp1[i] + VN) % VN < best) begin
                    best = (v - mp1[i] + VN) % VN;
                    cand[i] = v;
                end
        end
        for (int o = 0; o < PN; o++) begin
            win = -1;
            best = PN;
            for (int i = 0; i < PN; i++)
                if (cand[i] >= 0 && op_of(i, cand[i]) == o && (i - mp2[o] + PN) % PN < best) begin
                    best = (i - mp2[o] + PN) % PN;
                    win = i;
                end
            if (win >= 0 && !rst) begin
                e_valid[o] = 1'b1;
                e_sel[o*3 +: 3] = 3'(win);
                e_read[win*VN+cand[win]] = 1'b1;
                gin[o] = win;
                gvc[o] = cand[win];
            end
        end
    endfunction

    function automatic void model_commit();
        bit g, c;
        if (rst) begin
            merr = 1'b0;
            for (int o = 0; o < PN; o++) begin
                mp1[o] = 0;
                mp2[o] = 0;
                for (int d = 0; d < VN; d++) mcnt[o][d] = BS;
            end
            return;
        end
        for (int o = 0; o < PN; o++)
            for (int d = 0; d < VN; d++) begin
                g = e_valid[o] && dv_of(gin[o], gvc[o]) == d;
                c = cr[o*VN+d];
                if (g && !c) mcnt[o][d]--;
                else if (c && !g) begin
                    if (mcnt[o][d] == BS) merr = 1'b1;
                    else mcnt[o][d]++;
                end
            end
        for (int o = 0; o < PN; o++)
            if (e_valid[o]) begin
                mp1[gin[o]] = (gvc[o] + 1) % VN;
                mp2[o] = (gin[o] + 1) % PN;
            end
    endfunction

    task automatic clear_in();
        req = '0;
        op = '0;
        dvc = '0;
        cr = '0;
    endtask

    task automatic set_req(int i, int v, int o, int d);
        req[i*VN+v] = 1'b1;
        op[(i*VN+v)*3 +: 3] = 3'(o);
        dvc[i*VN+v] = d[0];
    endtask

    task automatic rand_in();
        req = 10'($urandom & $urandom);
        for (int k = 0; k < PN*VN; k++) op[k*3 +: 3] = 3'($urandom_range(0, PN-1));
        dvc = 10'($urandom);
        cr = 10'($urandom & $urandom);
    endtask

    task automatic settle();
        #1;
        model_eval();
    endtask

    task automatic advance();
        model_commit();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_in();
        settle();
        advance();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            rand_in();
            settle();
            n_checks++;
            if ({read_o, sel, valid} !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs read=%h sel=%h valid=%h exp all zero", read_o, sel, valid);
            end
            advance();
        end
        rst = 1'b0;
        clear_in();
    endtask

    task automatic test_single();
        do_reset();
        set_req(1, 0, 2, 1);
        settle();
        n_checks++;
        if (read_o !== 10'b0000000100 || valid !== 5'b00100 || sel[8:6] !== 3'd1) begin
            n_fail++;
            $display("FAIL single_grant read=%b valid=%b sel2=%0d exp read=0000000100 valid=00100 sel2=1", read_o, valid, sel[8:6]);
        end
        advance();
        clear_in();
        settle();
        n_checks++;
        if ({read_o, valid} !== '0) begin
            n_fail++;
            $display("FAIL single_idle read=%b valid=%b exp zero", read_o, valid);
        end
        advance();
    endtask

    task automatic test_rotation();
        do_reset();
        set_req(0, 0, 4, 0);
        set_req(1, 0, 4, 0);
        set_req(3, 0, 4, 0);
        cr[8] = 1'b1;
        for (int k = 0; k < 9; k++) begin
            settle();
            n_checks++;
            if (valid !== 5'b10000 || int'(sel[14:12]) != rot[k%3] || read_o !== 10'(1 << (rot[k%3]*2))) begin
                n_fail++;
                $display("FAIL rotation k=%0d valid=%b sel4=%0d read=%b exp sel4=%0d", k, valid, sel[14:12], read_o, rot[k%3]);
            end
            advance();
        end
        clear_in();
    endtask

    task automatic test_credit_exhaust();
        do_reset();
        set_req(0, 0, 3, 0);
        for (int k = 0; k < 9; k++) begin
            settle();
            n_checks++;
            if (valid[3] !== (k < 8)) begin
                n_fail++;
                $display("FAIL exhaust k=%0d valid3=%b exp %b", k, valid[3], k < 8);
            end
            advance();
        end
        cr[6] = 1'b1;
        settle();
        n_checks++;
        if (valid[3] !== 1'b0) begin
            n_fail++;
            $display("FAIL exhaust_credit_cycle valid3=%b exp 0", valid[3]);
        end
        advance();
        cr = '0;
        settle();
        n_checks++;
        if (valid[3] !== 1'b1 || read_o !== 10'b1) begin
            n_fail++;
            $display("FAIL exhaust_resume valid3=%b read=%b exp 1 / 0000000001", valid[3], read_o);
        end
        advance();
        clear_in();
    endtask

    task automatic test_same_cycle();
        int grants = 0;
        do_reset();
        set_req(0, 0, 3, 0);
        for (int k = 0; k < 3; k++) begin
            settle();
            advance();
        end
        cr[6] = 1'b1;
        settle();
        n_checks++;
        if (valid[3] !== 1'b1) begin
            n_fail++;
            $display("FAIL same_cycle_grant valid3=%b exp 1", valid[3]);
        end
        advance();
        cr = '0;
        for (int k = 0; k < 7; k++) begin
            settle();
            grants += int'(valid[3]);
            advance();
        end
        n_checks++;
        if (grants != 5) begin
            n_fail++;
            $display("FAIL same_cycle_count grants=%0d exp 5", grants);
        end
        clear_in();
    endtask

    task automatic test_vc_alternate();
        do_reset();
        set_req(0, 1, 1, 0);
        settle();
        n_checks++;
        if (read_o !== 10'b10) begin
            n_fail++;
            $display("FAIL vc_setup read=%b exp 0000000010", read_o);
        end
        advance();
        clear_in();
        set_req(0, 0, 1, 0);
        set_req(1, 0, 1, 0);
        settle();
        n_checks++;
        if (read_o !== 10'b100 || sel[5:3] !== 3'd1) begin
            n_fail++;
            $display("FAIL vc_stage2_loss read=%b sel1=%0d exp 0000000100 / 1", read_o, sel[5:3]);
        end
        advance();
        clear_in();
        set_req(0, 0, 1, 0);
        set_req(0, 1, 2, 0);
        for (int k = 0; k < 5; k++) begin
            settle();
            n_checks++;
            if (read_o[1:0] !== ((k % 2 == 0) ? 2'b01 : 2'b10) || {read_o, sel, valid} !== {e_read, e_sel, e_valid}) begin
                n_fail++;
                $display("FAIL vc_alternate k=%0d read=%b exp %b", k, read_o, e_read);
            end
            advance();
        end
        clear_in();
    endtask

    task automatic test_saturation();
        int grants = 0;
        do_reset();
        cr[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            settle();
            advance();
        end
        cr = '0;
        set_req(2, 1, 0, 0);
        for (int k = 0; k < 10; k++) begin
            settle();
`ifdef SWITCH_ALLOC_CREDIT_ERR_EN
            n_checks++;
            if (err !== 1'b1) begin
                n_fail++;
                $display("FAIL credit_err_sticky k=%0d err=%b exp 1", k, err);
            end
`endif
            grants += int'(valid[0]);
            advance();
        end
        n_checks++;
        if (grants != BS) begin
            n_fail++;
            $display("FAIL saturation grants=%0d exp %0d", grants, BS);
        end
        do_reset();
        settle();
`ifdef SWITCH_ALLOC_CREDIT_ERR_EN
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL credit_err_clear err=%b exp 0", err);
        end
`endif
    endtask

    task automatic test_reset_mid();
        int grants = 0;
        do_reset();
        for (int k = 0; k < 15; k++) begin
            rand_in();
            req = req | 10'b1010101010;
            cr = '0;
            settle();
            n_checks++;
            if ({read_o, sel, valid} !== {e_read, e_sel, e_valid}) begin
                n_fail++;
                $display("FAIL mid_traffic k=%0d read=%b sel=%h valid=%b exp read=%b sel=%h valid=%b", k, read_o, sel, valid, e_read, e_sel, e_valid);
            end
            advance();
        end
        rst = 1'b1;
        settle();
        n_checks++;
        if ({read_o, sel, valid} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs read=%b sel=%h valid=%b exp zero", read_o, sel, valid);
        end
        advance();
        rst = 1'b0;
        clear_in();
        set_req(4, 0, 0, 1);
        for (int k = 0; k < 10; k++) begin
            settle();
            grants += int'(valid[0]);
            advance();
        end
        n_checks++;
        if (grants != BS) begin
            n_fail++;
            $display("FAIL mid_reset_credits grants=%0d exp %0d", grants, BS);
        end
        clear_in();
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 400; k++) begin
            rand_in();
            rst = ($urandom_range(0, 49) == 0);
            settle();
            n_checks++;
            if ({read_o, sel, valid} !== {e_read, e_sel, e_valid}) begin
                n_fail++;
                $display("FAIL random k=%0d read=%b sel=%h valid=%b exp read=%b sel=%h valid=%b", k, read_o, sel, valid, e_read, e_sel, e_valid);
            end
`ifdef SWITCH_ALLOC_CREDIT_ERR_EN
            n_checks++;
            if (err !== merr) begin
                n_fail++;
                $display("FAIL random_err k=%0d err=%b exp %b", k, err, merr);
            end
`endif
            advance();
        end
        rst = 1'b0;
        clear_in();
    endtask

    initial begin
        rst = 1'b1;
        clear_in();
        @(negedge clk);
        test_reset();
        test_single();
        test_rotation();
        test_credit_exhaust();
        test_same_cycle();
        test_vc_alternate();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
